dmac_bus_arbiter: RTL and testbench

- Two-master AHB-lite bus arbiter that shares the system bus between the CPU master (M0) and the DMAC master interface (M1).
- Takes the DMAC main controller's bus request and lock/hold, and returns its bus grant.
- Drives address-phase and data-phase master select for the address/wdata muxes.
- The DMAC has fixed priority. A beat-count tenure limit with a one-transfer CPU backoff prevents CPU starvation during long DMA transfers.

---
 rtl/dmac_bus_arbiter.sv | 94 +++++++++
 tb/tb_dmac_bus_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dmac_bus_arbiter.sv
// Two-master AHB-lite arbiter between the CPU (M0) and the DMAC (M1). The DMAC has fixed priority.
// A beat-count tenure limit with a one-transfer CPU backoff keeps the CPU from being starved.
module dmac_bus_arbiter #(
  parameter int unsigned MAX_TENURE = 16,
  parameter int unsigned CNT_W      = $clog2(MAX_TENURE + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic       cpu_lock,
  input  logic       dma_req,
  input  logic       dma_lock,
  input  logic       HReady,
  input  logic [1:0] HTrans,
  output logic       cpu_grant,
  output logic       dma_grant,
  output logic       hmaster,
  output logic       hmaster_d,
  output logic       tenure_expired
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_TENURE);
  localparam logic [1:0]       TransNonseq = 2'b10;

  typedef enum logic [0:0] {StCpu, StDma} state_e;

  state_e           state_q, state_d;
  logic             hmaster_q, hmaster_data_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             backoff_q, backoff_d;
  logic             expired_q, expired_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    backoff_d = backoff_q;
    expired_d = 1'b0;
    if (HReady) begin
      // HTrans is only looked at under the owner qualifier, so an X from an idle master is masked.
      if (hmaster_q && HTrans[1] && (cnt_q != MaxCnt)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if ((!hmaster_q && (HTrans == TransNonseq)) || !cpu_req) begin
        backoff_d = 1'b0;
      end
      unique case (state_q)
        StCpu: begin
          if (dma_req && !cpu_lock && !backoff_q) begin
            state_d = StDma;
            cnt_d   = '0;
          end
        end
        StDma: begin
          if (!dma_req) begin
            state_d = StCpu;
          end else if (cpu_req && !dma_lock && (cnt_q >= MaxCnt)) begin
            state_d   = StCpu;
            backoff_d = 1'b1;
            expired_d = 1'b1;
          end
        end
        default: state_d = StCpu;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StCpu;
      hmaster_q      <= 1'b0;
      hmaster_data_q <= 1'b0;
      cnt_q          <= '0;
      backoff_q      <= 1'b0;
      expired_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      backoff_q <= backoff_d;
      // Pulse is cleared every cycle so it stays one cycle wide even across wait states.
      expired_q <= expired_d;
      if (HReady) begin
        hmaster_q      <= (state_q == StDma);
        hmaster_data_q <= hmaster_q;
      end
    end
  end

  assign cpu_grant      = (state_q == StCpu);
  assign dma_grant      = (state_q == StDma);
  assign hmaster        = hmaster_q;
  assign hmaster_d      = hmaster_data_q;
  assign tenure_expired = expired_q;

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// Self-checking bench for dmac_bus_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural ownership model.
module tb_dmac_bus_arbiter;

  localparam int MaxTenure = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_lock = 1'b0, dma_req = 1'b0, dma_lock = 1'b0;
  logic       HReady = 1'b1;
  logic [1:0] HTrans = 2'b00;
  logic       cpu_grant, dma_grant, hmaster, hmaster_d, tenure_expired;

  dmac_bus_arbiter #(.MAX_TENURE(MaxTenure)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_req       (cpu_req),
    .cpu_lock      (cpu_lock),
    .dma_req       (dma_req),
    .dma_lock      (dma_lock),
    .HReady        (HReady),
    .HTrans        (HTrans),
    .cpu_grant     (cpu_grant),
    .dma_grant     (dma_grant),
    .hmaster       (hmaster),
    .hmaster_d     (hmaster_d),
    .tenure_expired(tenure_expired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: who owns the grant, who owns each bus phase, accepted DMA beats, backoff flag.
  bit m_dma_owner, m_addr_dma, m_data_dma, m_backoff, m_expired;
  int m_beats;

  task automatic model_reset();
    m_dma_owner = 0; m_addr_dma = 0; m_data_dma = 0;
    m_backoff = 0; m_expired = 0; m_beats = 0;
  endtask

  // Applies one rising edge with the inputs that were stable across it.
  task automatic model_edge();
    bit next_owner, next_backoff;
    int next_beats;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_expired = 0;
    if (!HReady) return;
    next_owner   = m_dma_owner;
    next_beats   = m_beats;
    next_backoff = m_backoff;
    if (m_addr_dma && HTrans[1]) next_beats = (m_beats + 1 > MaxTenure) ? MaxTenure : m_beats + 1;
    if ((!m_addr_dma && HTrans == 2'b10) || !cpu_req) next_backoff = 0;
    if (!m_dma_owner) begin
      if (dma_req && !cpu_lock && !m_backoff) begin
        next_owner = 1;
        next_beats = 0;
      end
    end else if (!dma_req) begin
      next_owner = 0;
    end else if (cpu_req && !dma_lock && m_beats >= MaxTenure) begin
      next_owner   = 0;
      next_backoff = 1;
      m_expired    = 1;
    end
    m_data_dma  = m_addr_dma;
    m_addr_dma  = m_dma_owner;
    m_dma_owner = next_owner;
    m_beats     = next_beats;
    m_backoff   = next_backoff;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("cpu_grant", cpu_grant, !m_dma_owner);
    check("dma_grant", dma_grant, m_dma_owner);
    check("hmaster", hmaster, m_addr_dma);
    check("hmaster_d", hmaster_d, m_data_dma);
    check("tenure_expired", tenure_expired, m_expired);
  endtask

  // Advance to the next falling edge, step the model for the rising edge just passed, compare.
  task automatic tick();
    @(negedge clk);
    model_edge();
    check_model();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst cpu_grant", cpu_grant, 1'b1);
    check("rst dma_grant", dma_grant, 1'b0);
    check("rst hmaster", hmaster, 1'b0);
    check("rst hmaster_d", hmaster_d, 1'b0);
    check("rst tenure_expired", tenure_expired, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_lock = 0; dma_req = 0; dma_lock = 0; HReady = 1; HTrans = 2'b00;
  endtask

  // Expected dma_grant / tenure_expired / hmaster after each edge of the tenure scenario.
  bit exp_grant[10]   = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 1};
  bit exp_expired[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  bit exp_hm[10]      = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    model_reset();
    clear_inputs();
    @(negedge clk);
    async_reset();

    // Idle park on the CPU.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle cpu_grant", cpu_grant, 1'b1);
      check("idle hmaster", hmaster, 1'b0);
    end

    // Grant latency and release.
    dma_req = 1;
    tick(); check("lat dma_grant", dma_grant, 1'b1); check("lat hm0", hmaster, 1'b0);
    tick(); check("lat hmaster", hmaster, 1'b1); check("lat hmd0", hmaster_d, 1'b0);
    tick(); check("lat hmaster_d", hmaster_d, 1'b1);
    dma_req = 0;
    tick(); check("release cpu_grant", cpu_grant, 1'b1);
    tick(); tick();

    // Tenure preemption with CPU backoff.
    async_reset();
    clear_inputs();
    cpu_req = 1; dma_req = 1; HTrans = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("tenure dma_grant", dma_grant, exp_grant[i]);
      check("tenure expired", tenure_expired, exp_expired[i]);
      check("tenure hmaster", hmaster, exp_hm[i]);
      HTrans = 2'b11;
      if (i >= 7) HTrans = 2'b10;
    end

    // dma_lock overrides tenure; release hands over on the next edge.
    async_reset();
    clear_inputs();
    cpu_req = 1; dma_req = 1; dma_lock = 1; HTrans = 2'b10;
    for (int i = 0; i < 12; i++) begin
      tick();
      HTrans = 2'b11;
      if (i > 0) check("lock dma_grant", dma_grant, 1'b1);
      check("lock expired", tenure_expired, 1'b0);
    end
    dma_lock = 0;
    tick(); check("unlock cpu_grant", cpu_grant, 1'b1); check("unlock expired", tenure_expired, 1'b1);

    // Wait states freeze the handover.
    async_reset();
    clear_inputs();
    dma_req = 1; HTrans = 2'b10;
    tick(); tick(); tick();
    HReady = 0; dma_req = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wait dma_grant", dma_grant, 1'b1);
      check("wait hmaster", hmaster, 1'b1);
      check("wait hmaster_d", hmaster_d, 1'b1);
    end
    HReady = 1;
    tick(); check("wait handover", cpu_grant, 1'b1);

    // Reset mid-burst, then normal re-grant.
    async_reset();
    clear_inputs();
    dma_req = 1; HTrans = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick();
      HTrans = 2'b11;
    end
    async_reset();
    tick(); check("regrant dma_grant", dma_grant, 1'b1); check("regrant hm0", hmaster, 1'b0);
    tick(); check("regrant hmaster", hmaster, 1'b1);

    // Randomized traffic against the model.
    clear_inputs();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) dma_req = ~dma_req;
      if ($urandom_range(7) == 0) cpu_req = ~cpu_req;
      if ($urandom_range(29) == 0) dma_lock = ~dma_lock;
      cpu_lock = ($urandom_range(9) == 0);
      HReady   = ($urandom_range(3) != 0);
      HTrans   = 2'($urandom_range(3));
      if ($urandom_range(499) == 0) async_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
